// File: rtl/gpio_event_ctrl.sv
// rtl/gpio_event_ctrl.sv - multi-channel GPIO sync/debounce/edge-event block with sticky flags and irq
module gpio_event_ctrl #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                ena,
    input  logic [N_CH-1:0]     gpio_in,
    input  logic [2*N_CH-1:0]   edge_mode,
    input  logic [DEB_W-1:0]    deb_cycles,
    input  logic [N_CH-1:0]     irq_mask,
    input  logic [N_CH-1:0]     pending_clr,
    output logic [N_CH-1:0]     gpio_level,
    output logic [N_CH-1:0]     gpio_cmd,
    output logic [N_CH-1:0]     pending,
    output logic [N_CH-1:0]     overrun,
    output logic                irq
);

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [SYNC_STAGES-1:0] sync_d [N_CH];
    logic [DEB_W-1:0]       cnt_q  [N_CH];
    logic [DEB_W-1:0]       cnt_d  [N_CH];
    logic [N_CH-1:0]        level_q, level_d;
    logic [N_CH-1:0]        prev_q, prev_d;
    logic [N_CH-1:0]        cmd_q, cmd_d;
    logic [N_CH-1:0]        pending_q, pending_d;
    logic [N_CH-1:0]        overrun_q, overrun_d;
    logic                   irq_q, irq_d;
    logic [N_CH-1:0]        sync_out;
    logic [DEB_W-1:0]       deb_last;

    // A zero threshold behaves like one, so the last count index is never negative.
    assign deb_last = (deb_cycles == '0) ? '0 : deb_cycles - DEB_W'(1);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], gpio_in[i]};
            level_d[i] = level_q[i];
            cnt_d[i]   = cnt_q[i] + DEB_W'(1);
            if (sync_out[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= deb_last) begin
                // >= so a threshold lowered mid-count still fires on the next edge
                level_d[i] = sync_out[i];
                cnt_d[i]   = '0;
            end
            prev_d[i]    = level_q[i];
            cmd_d[i]     = (level_q[i] & ~prev_q[i] & edge_mode[2*i]) |
                           (~level_q[i] & prev_q[i] & edge_mode[2*i+1]);
            pending_d[i] = cmd_q[i] | (pending_q[i] & ~pending_clr[i]);
            // A clear in the same cycle as an event keeps pending but drops overrun.
            overrun_d[i] = ~pending_clr[i] & (overrun_q[i] | (cmd_q[i] & pending_q[i]));
        end
        irq_d = |(pending_q & irq_mask);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q   <= '0;
            prev_q    <= '0;
            cmd_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            irq_q     <= 1'b0;
        end else if (ena) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            level_q   <= level_d;
            prev_q    <= prev_d;
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign gpio_level = level_q;
    assign gpio_cmd   = cmd_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// tb/tb_gpio_event_ctrl.sv - directed self-checking bench for gpio_event_ctrl
module tb_gpio_event_ctrl;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] gpio_in = '0;
    logic [7:0] edge_mode = '0;
    logic [7:0] deb_cycles = 8'd3;
    logic [3:0] irq_mask = '0;
    logic [3:0] pending_clr = '0;
    logic [3:0] gpio_level, gpio_cmd, pending, overrun;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_event_ctrl #(.N_CH(4), .SYNC_STAGES(2), .DEB_W(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .gpio_in(gpio_in), .edge_mode(edge_mode),
        .deb_cycles(deb_cycles), .irq_mask(irq_mask), .pending_clr(pending_clr),
        .gpio_level(gpio_level), .gpio_cmd(gpio_cmd), .pending(pending),
        .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        tick(3);
        rstb = 1'b1;
        tick(2);
        checks++;
        if ({gpio_level, gpio_cmd, pending, overrun, irq} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {gpio_level, gpio_cmd, pending, overrun, irq});
        end
    endtask

    task automatic test_latency;
        logic [3:0] exp_v;
        deb_cycles = 8'd3;
        edge_mode  = 8'b0000_0001;
        irq_mask   = 4'b0001;
        gpio_in    = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_v = {k >= 8, k >= 7, k == 6, k >= 5};
            checks++;
            if ({irq, pending[0], gpio_cmd[0], gpio_level[0]} !== exp_v) begin
                errors++;
                $display("FAIL latency_edge%0d: {irq,pend,cmd,lvl}=%b expected %b", k,
                         {irq, pending[0], gpio_cmd[0], gpio_level[0]}, exp_v);
            end
        end
        pending_clr = 4'b0001;
        tick(1);
        pending_clr = 4'b0000;
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL latency_clear: pending=%b expected 0000", pending);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL latency_irq_drop: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_glitch;
        int n_cmd;
        logic seen_lvl;
        deb_cycles = 8'd4;
        edge_mode  = 8'b0000_0101;
        gpio_in[1] = 1'b1;
        tick(3);
        gpio_in[1] = 1'b0;
        n_cmd = 0;
        seen_lvl = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (gpio_cmd[1]) n_cmd++;
            if (gpio_level[1]) seen_lvl = 1'b1;
        end
        checks++;
        if ({seen_lvl, n_cmd[3:0], pending[1]} !== 6'd0) begin
            errors++;
            $display("FAIL glitch_short: lvl_seen=%b cmds=%0d pend=%b expected 0/0/0", seen_lvl, n_cmd, pending[1]);
        end
        gpio_in[1] = 1'b1;
        tick(6);
        gpio_in[1] = 1'b0;
        n_cmd = 0;
        seen_lvl = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (gpio_cmd[1]) n_cmd++;
            if (gpio_level[1]) seen_lvl = 1'b1;
        end
        checks++;
        if (n_cmd != 1 || seen_lvl !== 1'b1 || pending[1] !== 1'b1 || gpio_level[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_long: cmds=%0d lvl_seen=%b pend=%b lvl=%b expected 1/1/1/0",
                     n_cmd, seen_lvl, pending[1], gpio_level[1]);
        end
    endtask

    task automatic test_edge_modes;
        int cnt [4];
        int exp_cnt [4];
        exp_cnt = '{0, 2, 2, 4};
        cnt = '{0, 0, 0, 0};
        deb_cycles = 8'd1;
        edge_mode  = 8'b11_10_01_00;
        gpio_in    = 4'b0000;
        tick(10);
        pending_clr = 4'b1111;
        tick(1);
        pending_clr = 4'b0000;
        tick(2);
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL modes_pre_clear: pending=%b expected 0000", pending);
        end
        for (int p = 0; p < 2; p++) begin
            gpio_in = 4'b1111;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                for (int c = 0; c < 4; c++) if (gpio_cmd[c]) cnt[c]++;
            end
            checks++;
            if (gpio_level !== 4'b1111) begin
                errors++;
                $display("FAIL modes_level_high: level=%b expected 1111", gpio_level);
            end
            gpio_in = 4'b0000;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                for (int c = 0; c < 4; c++) if (gpio_cmd[c]) cnt[c]++;
            end
            checks++;
            if (gpio_level !== 4'b0000) begin
                errors++;
                $display("FAIL modes_level_low: level=%b expected 0000", gpio_level);
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (cnt[c] != exp_cnt[c]) begin
                errors++;
                $display("FAIL modes_cmd_count_ch%0d: got %0d expected %0d", c, cnt[c], exp_cnt[c]);
            end
        end
    endtask

    task automatic test_overrun;
        int wait_n;
        logic found;
        deb_cycles = 8'd0;
        pending_clr = 4'b1111;
        tick(1);
        pending_clr = 4'b0000;
        checks++;
        if ({pending, overrun} !== 8'd0) begin
            errors++;
            $display("FAIL ovr_initial_clear: pend=%b ovr=%b expected 0000/0000", pending, overrun);
        end
        for (int e = 0; e < 2; e++) begin
            gpio_in[2] = 1'b1;
            tick(6);
            gpio_in[2] = 1'b0;
            tick(6);
        end
        checks++;
        if (pending !== 4'b0100 || overrun !== 4'b0100) begin
            errors++;
            $display("FAIL ovr_two_events: pend=%b ovr=%b expected 0100/0100", pending, overrun);
        end
        pending_clr = 4'b0100;
        tick(1);
        pending_clr = 4'b0000;
        checks++;
        if (pending !== 4'b0000 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_w1c: pend=%b ovr=%b expected 0000/0000", pending, overrun);
        end
        gpio_in[2] = 1'b1;
        tick(6);
        gpio_in[2] = 1'b0;
        tick(6);
        checks++;
        if (pending !== 4'b0100 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_first_event: pend=%b ovr=%b expected 0100/0000", pending, overrun);
        end
        gpio_in[2] = 1'b1;
        tick(6);
        gpio_in[2] = 1'b0;
        found = 1'b0;
        wait_n = 0;
        while (!found && wait_n < 10) begin
            tick(1);
            wait_n++;
            if (gpio_cmd[2]) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL ovr_wait_cmd: cmd[2] seen=%b expected 1 within 10 cycles", found);
        end
        pending_clr = 4'b0100;
        tick(1);
        pending_clr = 4'b0000;
        checks++;
        if (pending[2] !== 1'b1 || overrun[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_set_clear_same_cycle: pend=%b ovr=%b expected 1/0", pending[2], overrun[2]);
        end
    endtask

    task automatic test_ena;
        logic [1:0] exp_v;
        deb_cycles = 8'd8;
        edge_mode  = 8'b11_10_01_01;
        irq_mask   = 4'b0000;
        gpio_in[0] = 1'b1;
        tick(5);
        ena = 1'b0;
        pending_clr = 4'b1111;
        gpio_in = 4'b0110;
        for (int k = 0; k < 10; k++) begin
            gpio_in[0] = ~gpio_in[0];
            tick(1);
        end
        checks++;
        if (gpio_level !== 4'b0000 || pending !== 4'b0100 || gpio_cmd !== 4'b0000) begin
            errors++;
            $display("FAIL ena_frozen: lvl=%b pend=%b cmd=%b expected 0000/0100/0000", gpio_level, pending, gpio_cmd);
        end
        gpio_in = 4'b0001;
        pending_clr = 4'b0000;
        ena = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_v = {k == 6, k >= 5};
            checks++;
            if ({gpio_cmd[0], gpio_level[0]} !== exp_v) begin
                errors++;
                $display("FAIL ena_resume_edge%0d: {cmd,lvl}=%b expected %b", k, {gpio_cmd[0], gpio_level[0]}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        logic bad;
        edge_mode  = 8'hFF;
        deb_cycles = 8'd1;
        irq_mask   = 4'b1111;
        gpio_in    = 4'b1111;
        tick(8);
        checks++;
        if (pending !== 4'b1111 || irq !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: pend=%b irq=%b expected 1111/1", pending, irq);
        end
        gpio_in = 4'b0000;
        #3;
        rstb = 1'b0;
        #1;
        checks++;
        if ({gpio_level, gpio_cmd, pending, overrun, irq} !== 17'd0) begin
            errors++;
            $display("FAIL areset_immediate: got %h expected 0", {gpio_level, gpio_cmd, pending, overrun, irq});
        end
        tick(1);
        rstb = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (gpio_cmd !== 4'b0000 || gpio_level !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL areset_quiet_after: activity=%b pend=%b expected 0/0000", bad, pending);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_edge_modes();
        test_overrun();
        test_ena();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/gpio_event_ctrl.md
Name: gpio_event_ctrl

Overview:
- Parametrised multi-channel GPIO event block, N_CH input pins.
- Per channel:
  - synchronizer;
  - programmable debounce filter;
  - per-channel edge-mode select (off / rising / falling / both);
  - one-cycle command pulse;
  - sticky pending and overrun flags with write-1-to-clear;
  - masked, registered interrupt.
- Sits between the chip GPIO pins and the control/register logic, e.g. start/stop/abort commands to the datapath FSM.

Parameters:
- N_CH, 4, number of GPIO channels (>=1).
- SYNC_STAGES, 2, synchronizer flop stages per channel (>=2).
- DEB_W, 8, width of debounce threshold and per-channel counter.

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- ena  input  1  global enable; when low, every flop holds its value.
- gpio_in  input  N_CH  raw asynchronous pins.
- edge_mode  input  2*N_CH  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- deb_cycles  input  DEB_W  stability threshold, shared by all channels.
- irq_mask  input  N_CH  1 = channel contributes to irq.
- pending_clr  input  N_CH  write-1-to-clear strobe for pending and overrun.
- gpio_level  output  N_CH  debounced (filtered) level.
- gpio_cmd  output  N_CH  one-cycle event pulse.
- pending  output  N_CH  sticky event flag.
- overrun  output  N_CH  sticky flag: event while pending already set.
- irq  output  1  registered OR of (pending & irq_mask).

Behaviour:
- Reset (rstb=0, asynchronous): all sync flops, gpio_level, counters, gpio_cmd, pending, overrun and irq go to 0.
- ena=0:
  - all state frozen, including sync stages, counters and flags;
  - gpio_cmd holds its last value; pending_clr is ignored.
- Synchronizer: SYNC_STAGES flops per channel, reset to 0. Output is s[i].
- Debounce, per channel; D = deb_cycles, with D=0 treated as D=1:
  - s[i] == gpio_level[i]: cnt <= 0.
  - s[i] != gpio_level[i] and cnt == D-1: gpio_level[i] <= s[i], cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than D cycles never reaches gpio_level. A mismatch that ends resets cnt.
- Edge detect, one cycle after a gpio_level[i] change, registered:
  - rising (0->1): gpio_cmd[i] <= 1 if mode is 01 or 11.
  - falling (1->0): gpio_cmd[i] <= 1 if mode is 10 or 11.
  - Otherwise gpio_cmd[i] <= 0.
  - Mode 00: no cmd, but gpio_level still tracks the input.
- Mode changes take effect on the next gpio_level transition. They never create a pulse by themselves.
- Latency (ena=1 throughout): pin change captured at clock edge 1 -> gpio_level updates at edge SYNC_STAGES+D -> gpio_cmd high for exactly one cycle at edge SYNC_STAGES+D+1.
- Pending / overrun update, per channel, on the cycle gpio_cmd[i]=1:
  - pending[i] <= 1.
  - If pending[i] was already 1: overrun[i] <= 1.
- Clear: pending_clr[i]=1 clears pending[i] and overrun[i] next edge.
- Simultaneous set and clear, same bit, same cycle: set wins.
  - pending stays 1.
  - overrun is not set by this cycle's event.
- irq <= |(pending & irq_mask), evaluated on the registered pending, so irq lags pending by 1 cycle. Changing the mask affects irq next cycle.
- Changing deb_cycles mid-count: the new threshold applies immediately. If cnt already >= D-1 and mismatch persists, gpio_level updates on the next edge.
- Channels are fully independent; simultaneous events on any subset are all captured.

Test Plan:
- Reset and latency, N_CH=4, SYNC_STAGES=2, deb_cycles=3, mode ch0=01:
  - release rstb with gpio_in=0 -> all outputs 0;
  - raise gpio_in[0] -> gpio_level[0]=1 at edge 5, gpio_cmd[0] single pulse at edge 6;
  - pending[0] at edge 7, irq at edge 8 with irq_mask[0]=1.
- Glitch rejection, deb_cycles=4: pulse gpio_in[1] high for 3 cycles -> gpio_level[1], gpio_cmd[1], pending[1] stay 0. Pulse for 6 cycles -> one rising cmd.
- Edge modes, toggle gpio_in[0..3] with modes 00/01/10/11 and D=1:
  - ch0 no cmd;
  - ch1 cmd on rise only;
  - ch2 cmd on fall only;
  - ch3 cmd on both (2 pulses per toggle pair);
  - gpio_level tracks on all four.
- Overrun and W1C:
  - two events on ch2 without clear -> pending[2]=1, overrun[2]=1;
  - pending_clr=4'b0100 -> both 0 next cycle;
  - clear asserted in the same cycle as gpio_cmd[2] -> pending[2]=1, overrun[2]=0.
- ena gating: drop ena mid-debounce for 10 cycles while gpio_in changes -> counters, flags and gpio_level frozen; pending_clr ignored; activity resumes from the frozen state when ena returns.
- Async reset mid-operation: assert rstb low between clock edges while pending=4'hF and irq=1 -> all outputs 0 immediately, no cmd pulse after release while gpio_in is stable at 0.
